// File: rtl/line_cmd_queue.sv
// line_cmd_queue: circular command FIFO feeding a line drawer.
// Commands are queued on push. One at a time, each is launched to the drawer
// with lda_go held high until lda_done. Every launch is followed by a
// one-cycle GAP, so lda_go is low for at least two cycles between commands.
// The in-flight command stays counted (and stored at head) until it completes.
module line_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLOCK_50,
  input  logic          resetN,
  input  logic          push,
  input  logic [8:0]    cmd_x0,
  input  logic [8:0]    cmd_x1,
  input  logic [7:0]    cmd_y0,
  input  logic [7:0]    cmd_y1,
  input  logic [2:0]    cmd_colour,
  input  logic          flush,
  output logic          full,
  output logic [AW:0]   count,
  output logic          dropped,
  output logic          busy,
  output logic          lda_go,
  output logic [8:0]    lda_x0,
  output logic [8:0]    lda_x1,
  output logic [7:0]    lda_y0,
  output logic [7:0]    lda_y1,
  output logic [2:0]    lda_colour,
  input  logic          lda_done
);

  localparam int ENTRY_W = 37;
  localparam int CNT_W   = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        head_q, head_d;
  logic [AW-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 dropped_q, dropped_d;
  logic                 busy_q, busy_d;
  logic                 go_q, go_d;
  logic [ENTRY_W-1:0]   cmd_q, cmd_d;
  logic [ENTRY_W-1:0]   mem_q [DEPTH];
  logic [ENTRY_W-1:0]   mem_d [DEPTH];

  logic [ENTRY_W-1:0]   wr_entry;
  logic                 accept;
  logic                 pop;
  logic                 launch;
  logic                 keep_inflight;

  // Entry layout: {x0, y0, x1, y1, colour}; uses the registered full flag so
  // a pop in the same cycle never rescues a push into a full queue. Flush
  // suppresses a launch from IDLE so nothing flushed can still be issued.
  always_comb begin
    wr_entry      = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour};
    accept        = push && !flush && !full_q;
    pop           = (state_q == ST_BUSY) && lda_done;
    launch        = (state_q == ST_IDLE) && (count_q != '0) && !flush;
    keep_inflight = (state_q == ST_BUSY) && !lda_done;
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: GAP always lasts exactly one cycle; done is only heard in BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch)   state_d = ST_BUSY;
      ST_BUSY: if (lda_done) state_d = ST_GAP;
      ST_GAP:                state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: load head entry on launch, drop go/busy on completion, else hold.
  always_comb begin
    go_d   = go_q;
    busy_d = busy_q;
    cmd_d  = cmd_q;
    if (launch) begin
      go_d   = 1'b1;
      busy_d = 1'b1;
      cmd_d  = mem_q[head_q];
    end else if (pop) begin
      go_d   = 1'b0;
      busy_d = 1'b0;
    end
  end

  // Queue bookkeeping: storage write, pointers, count, full and sticky drop flag.
  // On flush, only an in-flight entry that is not completing this cycle survives.
  always_comb begin
    mem_d = mem_q;
    if (accept) begin
      mem_d[tail_q] = wr_entry;
    end

    head_d = pop ? head_q + AW'(1) : head_q;

    if (flush) begin
      tail_d    = (state_q == ST_BUSY) ? head_q + AW'(1) : head_q;
      count_d   = keep_inflight ? CNT_W'(1) : '0;
      dropped_d = 1'b0;
    end else begin
      tail_d    = accept ? tail_q + AW'(1) : tail_q;
      count_d   = count_q + CNT_W'(accept) - CNT_W'(pop);
      dropped_d = dropped_q || (push && full_q);
    end

    full_d = (count_d == CNT_W'(DEPTH));
  end

  // Datapath registers; reset abandons any in-flight command and clears storage.
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      dropped_q <= 1'b0;
      busy_q    <= 1'b0;
      go_q      <= 1'b0;
      cmd_q     <= '0;
      mem_q     <= '{default: '0};
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      full_q    <= full_d;
      dropped_q <= dropped_d;
      busy_q    <= busy_d;
      go_q      <= go_d;
      cmd_q     <= cmd_d;
      mem_q     <= mem_d;
    end
  end

  assign full       = full_q;
  assign count      = count_q;
  assign dropped    = dropped_q;
  assign busy       = busy_q;
  assign lda_go     = go_q;
  assign lda_x0     = cmd_q[36:28];
  assign lda_y0     = cmd_q[27:20];
  assign lda_x1     = cmd_q[19:11];
  assign lda_y1     = cmd_q[10:3];
  assign lda_colour = cmd_q[2:0];

endmodule

// File: tb/tb_line_cmd_queue.sv
// tb_line_cmd_queue: scoreboard bench for line_cmd_queue.
// The driver keeps a small behavioural model (queue of accepted commands plus
// in-flight / cool-down bookkeeping); a separate monitor pops the scoreboard
// whenever the DUT raises lda_go and checks the launched command and spacing.
module tb_line_cmd_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct packed {
    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] x1;
    logic [7:0] y1;
    logic [2:0] colour;
  } cmd_t;

  logic          CLOCK_50 = 1'b0;
  logic          resetN;
  logic          push;
  logic [8:0]    cmd_x0, cmd_x1;
  logic [7:0]    cmd_y0, cmd_y1;
  logic [2:0]    cmd_colour;
  logic          flush;
  logic          full;
  logic [AW:0]   count;
  logic          dropped;
  logic          busy;
  logic          lda_go;
  logic [8:0]    lda_x0, lda_x1;
  logic [7:0]    lda_y0, lda_y1;
  logic [2:0]    lda_colour;
  logic          lda_done;

  line_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLOCK_50  (CLOCK_50),
    .resetN    (resetN),
    .push      (push),
    .cmd_x0    (cmd_x0),
    .cmd_x1    (cmd_x1),
    .cmd_y0    (cmd_y0),
    .cmd_y1    (cmd_y1),
    .cmd_colour(cmd_colour),
    .flush     (flush),
    .full      (full),
    .count     (count),
    .dropped   (dropped),
    .busy      (busy),
    .lda_go    (lda_go),
    .lda_x0    (lda_x0),
    .lda_x1    (lda_x1),
    .lda_y0    (lda_y0),
    .lda_y1    (lda_y1),
    .lda_colour(lda_colour),
    .lda_done  (lda_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int   checks = 0;
  int   errors = 0;

  // Scoreboard: accepted commands not yet launched, in arrival order.
  cmd_t exp_q[$];
  cmd_t last_cmd;

  // Behavioural model state.
  int   m_cnt;
  bit   m_inflight;
  int   m_cool;
  bit   m_drop;

  // Monitor state.
  bit   prev_go;
  int   low_run;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void resetModel();
    m_cnt      = 0;
    m_inflight = 0;
    m_cool     = 0;
    m_drop     = 0;
    exp_q.delete();
    last_cmd   = '0;
    prev_go    = 0;
    low_run    = 2;
  endfunction

  // One clock edge of the reference behaviour, using the values seen before the edge.
  function automatic void modelStep(input bit p, input cmd_t c, input bit f, input bit d);
    bit pop      = m_inflight && d;
    bit full_pre = (m_cnt == DEPTH);
    bit acc      = p && !f && !full_pre;
    bit launch   = !m_inflight && (m_cool == 0) && (m_cnt > 0) && !f;
    if (f) begin
      m_drop = 0;
      m_cnt  = (m_inflight && !pop) ? 1 : 0;
      exp_q.delete();
    end else begin
      if (p && full_pre) m_drop = 1;
      m_cnt = m_cnt + int'(acc) - int'(pop);
      if (acc) exp_q.push_back(c);
    end
    if (pop) begin
      m_inflight = 0;
      m_cool     = 1;
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (launch) begin
      m_inflight = 1;
    end
  endfunction

  function automatic cmd_t randCmd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[36:0];
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, then compare status outputs.
  task automatic applyStimulus(input bit p, input cmd_t c, input bit f, input bit d);
    @(negedge CLOCK_50);
    push     = p;
    {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour} = c;
    flush    = f;
    lda_done = d;
    @(posedge CLOCK_50);
    modelStep(p, c, f, d);
    #2;
    checkOutput("count",   64'(count),   64'(m_cnt));
    checkOutput("full",    64'(full),    64'(m_cnt == DEPTH));
    checkOutput("dropped", 64'(dropped), 64'(m_drop));
    checkOutput("busy",    64'(busy),    64'(m_inflight));
    checkOutput("lda_go",  64'(lda_go),  64'(m_inflight));
  endtask

  task automatic idle(input int n, input bit d);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, d);
  endtask

  // Monitor: on every launch pop the scoreboard; always check the held command and go spacing.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (resetN === 1'b1) begin
        if (lda_go && !prev_go) begin
          checkOutput("go_gap_ge2", 64'(low_run >= 2), 64'd1);
          checkOutput("launch_pending", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) last_cmd = exp_q.pop_front();
        end
        checkOutput("lda_cmd", 64'({lda_x0, lda_y0, lda_x1, lda_y1, lda_colour}), 64'(last_cmd));
        if (lda_go) low_run = 0;
        else        low_run++;
        prev_go = lda_go;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not end, %0d checks", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cmd_t c;
    resetN   = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    lda_done = 1'b0;
    {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour} = '0;
    resetModel();

    #3;
    checkOutput("rst_count",   64'(count),   64'd0);
    checkOutput("rst_full",    64'(full),    64'd0);
    checkOutput("rst_dropped", 64'(dropped), 64'd0);
    checkOutput("rst_busy",    64'(busy),    64'd0);
    checkOutput("rst_go",      64'(lda_go),  64'd0);
    checkOutput("rst_cmd",     64'({lda_x0, lda_y0, lda_x1, lda_y1, lda_colour}), 64'd0);
    @(negedge CLOCK_50);
    #1 resetN = 1'b1;

    // Single line (0,0)->(100,100) colour 7, then a done pulse and gap.
    c = '{x0: 9'd0, y0: 8'd0, x1: 9'd100, y1: 8'd100, colour: 3'd7};
    applyStimulus(1'b1, c, 1'b0, 1'b0);
    idle(3, 1'b0);
    checkOutput("single_x1", 64'(lda_x1), 64'd100);
    checkOutput("single_y1", 64'(lda_y1), 64'd100);
    checkOutput("single_col", 64'(lda_colour), 64'd7);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(4, 1'b0);

    // Five pushes with done held low: fourth fills, fifth is dropped; then drain.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, randCmd(), 1'b0, 1'b0);
    checkOutput("five_full", 64'(full), 64'd1);
    checkOutput("five_dropped", 64'(dropped), 64'd1);
    idle(20, 1'b1);

    // Push while full in the same cycle as done: push still dropped.
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, randCmd(), 1'b0, 1'b0);
    applyStimulus(1'b1, randCmd(), 1'b0, 1'b1);
    checkOutput("full_pop_count", 64'(count), 64'd3);
    idle(20, 1'b1);

    // Flush with one in flight and three waiting (after a drop so dropped clears).
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, randCmd(), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("flush_count", 64'(count), 64'd1);
    idle(3, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(6, 1'b0);

    // Asynchronous reset while busy, then a push on the first edge after release.
    applyStimulus(1'b1, randCmd(), 1'b0, 1'b0);
    applyStimulus(1'b1, randCmd(), 1'b0, 1'b0);
    @(negedge CLOCK_50);
    push = 1'b0;
    #1 resetN = 1'b0;
    #1;
    checkOutput("arst_go",    64'(lda_go), 64'd0);
    checkOutput("arst_count", 64'(count),  64'd0);
    checkOutput("arst_busy",  64'(busy),   64'd0);
    resetModel();
    @(negedge CLOCK_50);
    #1 resetN = 1'b1;
    applyStimulus(1'b1, randCmd(), 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(4, 1'b1);

    // Ten push/done rounds so both pointers wrap several times.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, randCmd(), 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
    end

    // Random traffic, including done in IDLE/GAP and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 50), randCmd(),
                    ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 40));
    end

    // Drain and confirm nothing remains expected.
    idle(30, 1'b1);
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
